// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter
// Merges PORT_NUM cache-side burst ports onto one downstream burst master.
// One transaction is in flight at a time: request, then data, then
// completion (for writes).
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid_i/req_ready_o        per-port request handshake (ready is one-hot)
//   req_write_i/addr_i/len_i       per-port request fields (len = beats-1)
//   wvalid_i/wdata_i/wready_o      per-port write beat channel
//   rvalid_o/rlast_o/rdata_o       read beats routed to the owner (data broadcast)
//   wdone_o                        one-cycle write completion pulse to the owner
//   m_req_*                        downstream request channel
//   m_w*                           downstream write beat channel (m_wlast_o generated here)
//   m_r*, m_bvalid_i               downstream read beats and write response
//   grant_o                        index of the current/last owner
//   busy_o                         high whenever a transaction is in progress
module cache_bus_arbiter #(
  parameter int PORT_NUM = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 8,
  parameter int RR_EN    = 1
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [PORT_NUM-1:0]                                 req_valid_i,
  input  logic [PORT_NUM-1:0]                                 req_write_i,
  input  logic [PORT_NUM*ADDR_W-1:0]                          req_addr_i,
  input  logic [PORT_NUM*LEN_W-1:0]                           req_len_i,
  output logic [PORT_NUM-1:0]                                 req_ready_o,
  input  logic [PORT_NUM-1:0]                                 wvalid_i,
  input  logic [PORT_NUM*DATA_W-1:0]                          wdata_i,
  output logic [PORT_NUM-1:0]                                 wready_o,
  output logic [PORT_NUM-1:0]                                 rvalid_o,
  output logic [PORT_NUM-1:0]                                 rlast_o,
  output logic [DATA_W-1:0]                                   rdata_o,
  output logic [PORT_NUM-1:0]                                 wdone_o,
  output logic                                                m_req_valid_o,
  input  logic                                                m_req_ready_i,
  output logic                                                m_req_write_o,
  output logic [ADDR_W-1:0]                                   m_req_addr_o,
  output logic [LEN_W-1:0]                                    m_req_len_o,
  output logic                                                m_wvalid_o,
  input  logic                                                m_wready_i,
  output logic [DATA_W-1:0]                                   m_wdata_o,
  output logic                                                m_wlast_o,
  input  logic                                                m_rvalid_i,
  input  logic [DATA_W-1:0]                                   m_rdata_i,
  input  logic                                                m_rlast_i,
  input  logic                                                m_bvalid_i,
  output logic [((PORT_NUM > 1) ? $clog2(PORT_NUM) : 1)-1:0]  grant_o,
  output logic                                                busy_o
);

  localparam int GW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, RDATA, WDATA, WRESP} state_t;

  state_t              state;
  logic [GW-1:0]       grant_q;
  logic [GW-1:0]       rr_ptr;
  // One extra bit so a len of 2^LEN_W-1 cannot wrap into an early last.
  logic [LEN_W:0]      beat_cnt;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [LEN_W-1:0]    lat_len;

  logic                win_found;
  logic [GW-1:0]       win_idx;
  logic [GW-1:0]       rr_next;
  logic                win_write;
  logic [ADDR_W-1:0]   win_addr;
  logic [LEN_W-1:0]    win_len;
  logic                can_grant;
  logic [DATA_W-1:0]   wdata_sel;
  logic                wvalid_sel;
  logic                last_beat;

  // Arbitration: scan from rr_ptr (round-robin) or from 0 (fixed priority),
  // wrapping by subtraction so non-power-of-2 port counts work.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < PORT_NUM; i++) begin
      cand = (RR_EN != 0) ? int'(rr_ptr) + i : i;
      if (cand >= PORT_NUM) cand = cand - PORT_NUM;
      if (!win_found && req_valid_i[GW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = GW'(cand);
      end
    end
  end

  assign rr_next   = (win_idx == GW'(PORT_NUM - 1)) ? '0 : win_idx + 1'b1;
  assign can_grant = (state == IDLE) && win_found && !rst;

  // Field muxes for the arbitration winner and the current owner.
  always_comb begin
    win_write  = 1'b0;
    win_addr   = '0;
    win_len    = '0;
    wdata_sel  = '0;
    wvalid_sel = 1'b0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (GW'(i) == win_idx) begin
        win_write = req_write_i[i];
        win_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
        win_len   = req_len_i[i*LEN_W +: LEN_W];
      end
      if (GW'(i) == grant_q) begin
        wdata_sel  = wdata_i[i*DATA_W +: DATA_W];
        wvalid_sel = wvalid_i[i];
      end
    end
  end

  assign last_beat = (beat_cnt == {1'b0, lat_len});

  // Request fields captured at grant; outputs are gated by state so they
  // need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && win_found) begin
      lat_write <= win_write;
      lat_addr  <= win_addr;
      lat_len   <= win_len;
    end
  end

  // Transaction FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_q  <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      wdone_o  <= '0;
    end else begin
      wdone_o <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_q <= win_idx;
            rr_ptr  <= rr_next;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (m_req_ready_i) begin
            beat_cnt <= '0;
            state    <= lat_write ? WDATA : RDATA;
          end
        end
        RDATA: begin
          if (m_rvalid_i) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (m_rlast_i) state <= IDLE;
          end
        end
        WDATA: begin
          if (wvalid_sel && m_wready_i) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) state <= WRESP;
          end
        end
        WRESP: begin
          if (m_bvalid_i) begin
            wdone_o[grant_q] <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output routing: everything toward upstream ports is zero outside the
  // state that owns that path.
  always_comb begin
    req_ready_o = '0;
    wready_o    = '0;
    rvalid_o    = '0;
    rlast_o     = '0;
    rdata_o     = '0;
    m_wvalid_o  = 1'b0;
    m_wdata_o   = '0;
    m_wlast_o   = 1'b0;
    if (can_grant) req_ready_o[win_idx] = 1'b1;
    if (state == RDATA) begin
      rvalid_o[grant_q] = m_rvalid_i;
      rlast_o[grant_q]  = m_rlast_i;
      rdata_o           = m_rdata_i;
    end
    if (state == WDATA) begin
      m_wvalid_o        = wvalid_sel;
      m_wdata_o         = wdata_sel;
      m_wlast_o         = last_beat;
      wready_o[grant_q] = m_wready_i;
    end
  end

  assign m_req_valid_o = (state == ADDR);
  assign m_req_write_o = (state == ADDR) && lat_write;
  assign m_req_addr_o  = (state == ADDR) ? lat_addr : '0;
  assign m_req_len_o   = (state == ADDR) ? lat_len : '0;
  assign grant_o       = grant_q;
  assign busy_o        = (state != IDLE);

  // Downstream ended a read burst with a beat count different from the
  // requested length; the transaction still completes.
  a_rlast_len: assert property (@(posedge clk) disable iff (rst)
    (state == RDATA && m_rvalid_i && m_rlast_i) |-> (beat_cnt == {1'b0, lat_len}));

endmodule

// File: tb/tb_cache_bus_arbiter.sv
module tb_cache_bus_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid[2], req_write[2], req_ready[2];
  logic [N-1:0]    wvalid[2], wready[2], rvalid[2], rlast[2], wdone[2];
  logic [N*AW-1:0] req_addr[2];
  logic [N*LW-1:0] req_len[2];
  logic [N*DW-1:0] wdata[2];
  logic [DW-1:0]   rdata[2];
  logic            m_req_valid[2], m_req_ready[2], m_req_write[2];
  logic [AW-1:0]   m_req_addr[2];
  logic [LW-1:0]   m_req_len[2];
  logic            m_wvalid[2], m_wready[2], m_wlast[2];
  logic [DW-1:0]   m_wdata[2];
  logic            m_rvalid[2], m_rlast[2], m_bvalid[2];
  logic [DW-1:0]   m_rdata[2];
  logic [GW-1:0]   grant[2];
  logic            busy[2];

  // Instance 0 is round-robin, instance 1 is fixed priority.
  for (genvar d = 0; d < 2; d++) begin : g_dut
    cache_bus_arbiter #(
      .PORT_NUM(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RR_EN((d == 0) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid[d]), .req_write_i(req_write[d]),
      .req_addr_i(req_addr[d]), .req_len_i(req_len[d]), .req_ready_o(req_ready[d]),
      .wvalid_i(wvalid[d]), .wdata_i(wdata[d]), .wready_o(wready[d]),
      .rvalid_o(rvalid[d]), .rlast_o(rlast[d]), .rdata_o(rdata[d]), .wdone_o(wdone[d]),
      .m_req_valid_o(m_req_valid[d]), .m_req_ready_i(m_req_ready[d]),
      .m_req_write_o(m_req_write[d]), .m_req_addr_o(m_req_addr[d]), .m_req_len_o(m_req_len[d]),
      .m_wvalid_o(m_wvalid[d]), .m_wready_i(m_wready[d]), .m_wdata_o(m_wdata[d]),
      .m_wlast_o(m_wlast[d]), .m_rvalid_i(m_rvalid[d]), .m_rdata_i(m_rdata[d]),
      .m_rlast_i(m_rlast[d]), .m_bvalid_i(m_bvalid[d]),
      .grant_o(grant[d]), .busy_o(busy[d])
    );
  end

  int n_chk = 0;
  int n_err = 0;

  // Reference model: pending requests per port and the round-robin pointer.
  bit          pend[2][N];
  bit          pw[2][N];
  logic [31:0] pa[2][N];
  int          pl[2][N];
  int          rr_ptr_m[2];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [127:0] all_out(input int d);
    return {2'b00, req_ready[d], wready[d], rvalid[d], rlast[d], rdata[d], wdone[d],
            m_req_valid[d], m_req_write[d], m_req_addr[d], m_req_len[d],
            m_wvalid[d], m_wdata[d], m_wlast[d], grant[d], busy[d]};
  endfunction

  // Winner rule: first pending port at or after the pointer (wrapping) for
  // round-robin, lowest pending index for fixed priority.
  function automatic int model_winner(input int d);
    int start;
    start = (d == 0) ? rr_ptr_m[d] : 0;
    for (int k = 0; k < N; k++) begin
      if (pend[d][(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic clear_inputs(input int d);
    req_valid[d] = '0; req_write[d] = '0; req_addr[d] = '0; req_len[d] = '0;
    wvalid[d] = '0; wdata[d] = '0; m_req_ready[d] = 1'b0; m_wready[d] = 1'b0;
    m_rvalid[d] = 1'b0; m_rdata[d] = '0; m_rlast[d] = 1'b0; m_bvalid[d] = 1'b0;
    for (int p = 0; p < N; p++) pend[d][p] = 1'b0;
  endtask

  task automatic set_req(input int d, input int p, input bit w, input logic [31:0] a, input int l);
    pend[d][p] = 1'b1; pw[d][p] = w; pa[d][p] = a; pl[d][p] = l;
    req_valid[d][p] = 1'b1;
    req_write[d][p] = w;
    req_addr[d][p*AW +: AW] = a;
    req_len[d][p*LW +: LW] = LW'(l);
  endtask

  // Runs one full transaction for port p, which the model expects to win.
  // rgap/wdelay < 0 selects random spacing, otherwise a fixed count.
  task automatic serve(input int d, input int p, input int rgap, input int wdelay);
    int len, k, g;
    bit w;
    len = pl[d][p];
    w   = pw[d][p];
    #1;
    chk("idle_busy", 128'(busy[d]), 128'(0));
    chk("req_ready", 128'(req_ready[d]), 128'(1 << p));
    tick;
    pend[d][p] = 1'b0;
    req_valid[d][p] = 1'b0;
    if (d == 0) rr_ptr_m[d] = (p + 1) % N;
    k = $urandom_range(0, 2);
    for (int i = 0; i <= k; i++) begin
      m_req_ready[d] = (i == k);
      #1;
      chk("m_req_valid", 128'(m_req_valid[d]), 128'(1));
      chk("grant", 128'(grant[d]), 128'(p));
      chk("m_req_addr", 128'(m_req_addr[d]), 128'(pa[d][p]));
      chk("m_req_len", 128'(m_req_len[d]), 128'(len));
      chk("m_req_write", 128'(m_req_write[d]), 128'(w));
      chk("req_ready_busy", 128'(req_ready[d]), 128'(0));
      chk("wdone_clr", 128'(wdone[d]), 128'(0));
      tick;
    end
    m_req_ready[d] = 1'b0;
    if (!w) begin
      for (int b = 0; b <= len; b++) begin
        g = (rgap < 0) ? int'($urandom_range(0, 2)) : rgap;
        m_rvalid[d] = 1'b0; m_rlast[d] = 1'b0;
        for (int i = 0; i < g; i++) begin
          #1;
          chk("rvalid_gap", 128'(rvalid[d]), 128'(0));
          chk("busy_r", 128'(busy[d]), 128'(1));
          tick;
        end
        m_rvalid[d] = 1'b1; m_rdata[d] = $urandom; m_rlast[d] = (b == len);
        #1;
        chk("rvalid", 128'(rvalid[d]), 128'(1 << p));
        chk("rdata", 128'(rdata[d]), 128'(m_rdata[d]));
        chk("rlast", 128'(rlast[d]), 128'((b == len) ? (1 << p) : 0));
        chk("grant_r", 128'(grant[d]), 128'(p));
        chk("req_ready_r", 128'(req_ready[d]), 128'(0));
        tick;
      end
      m_rvalid[d] = 1'b0; m_rlast[d] = 1'b0;
    end else begin
      for (int b = 0; b <= len; b++) begin
        g = (wdelay < 0) ? int'($urandom_range(0, 2)) : wdelay;
        wvalid[d][p] = 1'b1;
        wdata[d][p*DW +: DW] = $urandom;
        m_wready[d] = 1'b0;
        for (int i = 0; i < g; i++) begin
          #1;
          chk("m_wvalid_wait", 128'(m_wvalid[d]), 128'(1));
          chk("wready_wait", 128'(wready[d]), 128'(0));
          chk("m_wlast_wait", 128'(m_wlast[d]), 128'(b == len));
          chk("grant_w", 128'(grant[d]), 128'(p));
          tick;
        end
        m_wready[d] = 1'b1;
        #1;
        chk("m_wvalid", 128'(m_wvalid[d]), 128'(1));
        chk("m_wdata", 128'(m_wdata[d]), 128'(wdata[d][p*DW +: DW]));
        chk("m_wlast", 128'(m_wlast[d]), 128'(b == len));
        chk("wready", 128'(wready[d]), 128'(1 << p));
        tick;
      end
      // Response wait: keep the upstream beat valid and downstream ready high
      // to see that neither leaks through.
      k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++) begin
        #1;
        chk("wresp_busy", 128'(busy[d]), 128'(1));
        chk("wresp_m_wvalid", 128'(m_wvalid[d]), 128'(0));
        chk("wresp_wready", 128'(wready[d]), 128'(0));
        chk("wresp_wdone", 128'(wdone[d]), 128'(0));
        tick;
      end
      m_bvalid[d] = 1'b1;
      #1;
      chk("wdone_early", 128'(wdone[d]), 128'(0));
      tick;
      m_bvalid[d] = 1'b0; wvalid[d][p] = 1'b0; m_wready[d] = 1'b0;
      #1;
      chk("wdone", 128'(wdone[d]), 128'(1 << p));
      chk("grant_wdone", 128'(grant[d]), 128'(p));
    end
    #1;
    chk("done_idle", 128'(busy[d]), 128'(0));
  endtask

  task automatic rand_phase(input int d, input int iters);
    int w;
    for (int it = 0; it < iters; it++) begin
      for (int p = 0; p < N; p++)
        if (!pend[d][p] && $urandom_range(0, 1) == 1)
          set_req(d, p, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 5));
      w = model_winner(d);
      if (w < 0) begin
        set_req(d, $urandom_range(0, N - 1), 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 5));
        w = model_winner(d);
      end
      serve(d, w, -1, -1);
    end
    while (model_winner(d) >= 0) serve(d, model_winner(d), -1, -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int w;
    rst = 1'b1;
    clear_inputs(0); clear_inputs(1);
    rr_ptr_m[0] = 0; rr_ptr_m[1] = 0;
    tick; tick;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("reset_out0", all_out(0), 128'(0));
      chk("reset_out1", all_out(1), 128'(0));
    end

    // Round-robin with all three ports continuously reading len=3.
    for (int p = 0; p < N; p++) set_req(0, p, 1'b0, $urandom, 3);
    for (int r = 0; r < 4; r++) begin
      w = model_winner(0);
      serve(0, w, -1, -1);
      set_req(0, w, 1'b0, $urandom, 3);
    end
    while (model_winner(0) >= 0) serve(0, model_winner(0), -1, -1);
    rand_phase(0, 12);

    // Fixed priority: port 0 keeps re-requesting, port 1 waits.
    set_req(1, 0, 1'($urandom_range(0, 1)), $urandom, 2);
    set_req(1, 1, 1'($urandom_range(0, 1)), $urandom, 1);
    for (int r = 0; r < 3; r++) begin
      serve(1, model_winner(1), -1, -1);
      if (r < 2) set_req(1, 0, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
    end
    serve(1, model_winner(1), -1, -1);
    rand_phase(1, 8);

    // Single-beat write from port 1 with a 3-cycle downstream ready delay.
    set_req(0, 1, 1'b1, 32'h1c00_0000, 0);
    serve(0, model_winner(0), -1, 3);

    // Maximum-length read with valid toggling every cycle.
    set_req(0, 2, 1'b0, $urandom, 255);
    serve(0, model_winner(0), 1, -1);

    // Reset in the middle of a 4-beat write granted to port 1.
    set_req(0, 1, 1'b1, 32'h2000_0040, 3);
    #1;
    chk("rst_pre_ready", 128'(req_ready[0]), 128'(2));
    tick;
    pend[0][1] = 1'b0; req_valid[0][1] = 1'b0; rr_ptr_m[0] = 2;
    m_req_ready[0] = 1'b1;
    #1;
    chk("rst_pre_addr", 128'(m_req_valid[0]), 128'(1));
    tick;
    m_req_ready[0] = 1'b0;
    wvalid[0][1] = 1'b1; m_wready[0] = 1'b1;
    #1;
    chk("rst_pre_wlast", 128'(m_wlast[0]), 128'(0));
    tick; tick;
    #1;
    chk("rst_pre_busy", 128'(busy[0]), 128'(1));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    clear_inputs(0);
    rr_ptr_m[0] = 0; rr_ptr_m[1] = 0;
    #1;
    chk("rst_mid_out0", all_out(0), 128'(0));
    chk("rst_mid_out1", all_out(1), 128'(0));
    set_req(0, 1, 1'b0, $urandom, 1);
    set_req(0, 2, 1'b0, $urandom, 1);
    while (model_winner(0) >= 0) serve(0, model_winner(0), -1, -1);

    tick;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/cache_bus_arbiter.md
# cache_bus_arbiter

Parametrised N-port arbiter that merges the cache-side bus ports (I-cache, D-cache, and future ports such as an uncached or prefetch port) onto one downstream burst master toward the AXI converter. It replaces the fixed two-port merge. New features:
- any port count;
- selectable fixed-priority or round-robin arbitration;
- write-burst beat counting with a generated last flag;
- per-port write-completion pulses.

It holds one transaction at a time, from request through data through completion.

## Interface
Parameters:
- PORT_NUM, 2, number of upstream request ports (≥1)
- ADDR_W, 32, address width
- DATA_W, 32, data beat width
- LEN_W, 8, burst length field width (value = beats−1)
- RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  PORT_NUM  per-port request valid; held until req_ready_o
- req_write_i  in  PORT_NUM  1 = write burst
- req_addr_i  in  PORT_NUM*ADDR_W  burst start address
- req_len_i  in  PORT_NUM*LEN_W  beats−1
- req_ready_o  out  PORT_NUM  one-hot request accept
- wvalid_i  in  PORT_NUM  write beat valid
- wdata_i  in  PORT_NUM*DATA_W  write beat data
- wready_o  out  PORT_NUM  write beat accept
- rvalid_o  out  PORT_NUM  read beat valid, routed to granted port
- rlast_o  out  PORT_NUM  last read beat
- rdata_o  out  DATA_W  read data, broadcast to all ports
- wdone_o  out  PORT_NUM  one-cycle write-completion pulse
- m_req_valid_o / m_req_ready_i  out/in  1  downstream request handshake
- m_req_write_o  out  1  downstream write flag
- m_req_addr_o  out  ADDR_W  downstream address
- m_req_len_o  out  LEN_W  downstream length
- m_wvalid_o / m_wready_i  out/in  1  downstream write beat handshake
- m_wdata_o  out  DATA_W  downstream write data
- m_wlast_o  out  1  downstream write last
- m_rvalid_i  in  1  read beat valid
- m_rdata_i  in  DATA_W  read beat data
- m_rlast_i  in  1  read last
- m_bvalid_i  in  1  write response
- grant_o  out  max(1,$clog2(PORT_NUM))  index of the current owner
- busy_o  out  1  state ≠ IDLE

## Operation
The arbiter is a five-state FSM: IDLE, ADDR, RDATA, WDATA, WRESP.

**IDLE**
- If any req_valid_i is set, select winner g:
  - RR_EN=0: lowest set index.
  - RR_EN=1: first set index at or after rr_ptr, wrapping modulo PORT_NUM. This must work for non-power-of-2 PORT_NUM.
- In the same cycle: req_ready_o[g]=1, latch write/addr/len of port g, set grant_o=g, set rr_ptr=(g+1) mod PORT_NUM, then go to ADDR.
- rr_ptr advances only on a grant.

**ADDR**
- m_req_valid_o=1 with the latched fields, held stable until m_req_ready_i.
- When m_req_ready_i is seen: go to WDATA if write, otherwise RDATA. Clear beat_cnt.

**RDATA**
- rvalid_o[g]=m_rvalid_i, rdata_o=m_rdata_i, rlast_o[g]=m_rlast_i.
- beat_cnt increments on each m_rvalid_i.
- On m_rlast_i: go to IDLE.
- If beat_cnt ≠ latched len when m_rlast_i arrives, the transaction still ends (downstream is authoritative). This case is reported only by the simulation assertion.

**WDATA**
- Pass through: m_wvalid_o=wvalid_i[g], m_wdata_o=wdata_i[g], wready_o[g]=m_wready_i.
- m_wlast_o=(beat_cnt==len).
- beat_cnt increments on each m_wvalid_o&&m_wready_i.
- After the handshake on the last beat: go to WRESP.

**WRESP**
- On m_bvalid_i: wdone_o[g]=1 for that cycle, then go to IDLE.

**General**
- All non-granted ports see ready/valid=0.
- Outputs toward upstream ports are zero outside their routing states.

## Timing
- Reset value of every output is 0. Reset also sets state=IDLE, rr_ptr=0, grant_o=0, beat_cnt=0.
- Reset mid-transaction abandons the transaction immediately. The downstream master must be reset in the same cycle.
- Latency from req_valid_i (in IDLE) to m_req_valid_o is 1 cycle.
- After completion there is at least 1 IDLE cycle before the next grant (no back-to-back grant in the completion cycle).
- All data paths in RDATA/WDATA are combinational pass-through: 0 added latency, full throughput.
- len=0 means a single beat; m_wlast_o is high on the first write beat.
- len=2^LEN_W−1 requires beat_cnt width LEN_W+1 or a wrap-safe compare. Either way there must be no early last.
- PORT_NUM=1: grant_o is 1 bit, always 0, and the arbiter degenerates to a pass-through FSM.
- Requests arriving during non-IDLE states wait. Their req_ready_o stays 0.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, busy_o=0.
- RR_EN=1, PORT_NUM=3, all ports request reads with len=3 continuously → grants in order 0,1,2,0. Each port receives 4 rvalid beats, with rlast_o on the 4th.
- RR_EN=0, ports 0 and 1 request together repeatedly → port 0 always wins. Port 1 is granted only once port 0 drops valid.
- Write from port 1, len=0, addr 0x1c000000, m_wready_i delayed 3 cycles → m_wlast_o=1 on the single beat. wdone_o[1] pulses exactly 1 cycle after m_bvalid_i is seen. grant_o=1 throughout.
- Read burst len=255 with m_rvalid_i toggling each cycle → 256 beats delivered, return to IDLE only after m_rlast_i.
- Assert rst during WDATA of a 4-beat write → the next cycle shows state IDLE and all outputs 0. A new request is then granted normally, with rr_ptr restarting at 0.
